// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction encoder/loader.
// Holds the 16-bit instruction field positions, the field-format selector,
// the reject-cause codes reported by the loader, and the loader FSM states.
package isa_pkg;

    localparam int unsigned OPC_W   = 4;
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned RD_LSB  = 9;
    localparam int unsigned RA_LSB  = 6;
    localparam int unsigned RB_LSB  = 3;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_RSV = 2'd3
    } fmt_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_IMM  = 2'd1,
        ERR_ADDR = 2'd2,
        ERR_FMT  = 2'd3
    } err_code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FULL  = 2'd3
    } load_state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational instruction packer.
// Builds the 16-bit instruction word from its fields and flags tuples that
// cannot be represented.
//   fmt       : 0=R, 1=I, 2=J, 3=reserved (always rejected)
//   opcode    : inst[15:12]
//   rd/ra/rb  : register addresses
//   func      : ALU function (R format)
//   imm       : signed immediate, must fit 6 bits (I format)
//   addr      : signed jump address, must fit 7 bits (J format)
//   word      : packed instruction
//   range_err : tuple must not be written
//   err_code  : cause of range_err (ERR_NONE when clean)
module instr_pack
    import isa_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [3:0]  opcode,
    input  logic [2:0]  rd_addr,
    input  logic [2:0]  ra_addr,
    input  logic [2:0]  rb_addr,
    input  logic [2:0]  func,
    input  logic [7:0]  imm,
    input  logic [7:0]  addr,
    output logic [15:0] word,
    output logic        range_err,
    output logic [1:0]  err_code
);

    always_comb begin
        word      = '0;
        range_err = 1'b0;
        err_code  = ERR_NONE;
        word[OPC_MSB -: OPC_W] = opcode;
        case (fmt_t'(fmt))
            FMT_R: begin
                word[RD_LSB +: 3] = rd_addr;
                word[RA_LSB +: 3] = ra_addr;
                word[RB_LSB +: 3] = rb_addr;
                word[2:0]         = func;
            end
            FMT_I: begin
                // imm is split around ra/rb: high half in the rd slot
                word[RD_LSB +: 3] = imm[5:3];
                word[RA_LSB +: 3] = ra_addr;
                word[RB_LSB +: 3] = rb_addr;
                word[2:0]         = imm[2:0];
                // sign bits 7..5 must agree so the 6-bit field sign-extends back
                if (!(imm[7:5] == 3'b000 || imm[7:5] == 3'b111)) begin
                    range_err = 1'b1;
                    err_code  = ERR_IMM;
                end
            end
            FMT_J: begin
                word[RD_LSB +: 3] = rd_addr;
                word[6:0]         = addr[6:0];
                if (addr[7] != addr[6]) begin
                    range_err = 1'b1;
                    err_code  = ERR_ADDR;
                end
            end
            default: begin
                range_err = 1'b1;
                err_code  = ERR_FMT;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader.
// Accepts instruction field tuples over valid/ready, packs them into 16-bit
// words and streams them to instruction memory at consecutive addresses
// starting from base_addr, stopping after the top address is written.
//   start/base_addr : arm (or re-arm) the loader at base_addr
//   in_valid/in_ready + fmt..addr : field tuple input
//   wr_valid/wr_ready/wr_addr/wr_data : memory write port (one output register)
//   busy  : loader armed
//   full  : top address written, loader stopped
//   err/err_code : sticky reject flag and first reject cause
//   words_written : writes completed since the last start
module instr_encoder_loader
    import isa_pkg::*;
#(
    parameter int unsigned IMEM_AW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [IMEM_AW-1:0] base_addr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         fmt,
    input  logic [3:0]         opcode,
    input  logic [2:0]         rd_addr,
    input  logic [2:0]         ra_addr,
    input  logic [2:0]         rb_addr,
    input  logic [2:0]         func,
    input  logic [7:0]         imm,
    input  logic [7:0]         addr,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [IMEM_AW-1:0] wr_addr,
    output logic [15:0]        wr_data,
    output logic               busy,
    output logic               full,
    output logic               err,
    output logic [1:0]         err_code,
    output logic [IMEM_AW:0]   words_written
);

    load_state_t state, state_next;
    err_code_t   code_q;

    logic [15:0] pk_word;
    logic        pk_err;
    logic [1:0]  pk_code;
    logic        accept;
    logic        write_fire;
    logic        top_write;

    instr_pack u_pack (
        .fmt       (fmt),
        .opcode    (opcode),
        .rd_addr   (rd_addr),
        .ra_addr   (ra_addr),
        .rb_addr   (rb_addr),
        .func      (func),
        .imm       (imm),
        .addr      (addr),
        .word      (pk_word),
        .range_err (pk_err),
        .err_code  (pk_code)
    );

    // wr_addr doubles as the write pointer: it only advances when the
    // pending word is accepted, so a word loaded in the same cycle picks
    // up the next address.
    assign write_fire = wr_valid && wr_ready;
    assign top_write  = write_fire && (wr_addr == '1);
    assign accept     = in_valid && in_ready;
    assign err_code   = code_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ST_LOAD;
        end else begin
            case (state)
                ST_LOAD:  if (top_write) state_next = ST_DRAIN;
                ST_DRAIN: state_next = ST_FULL;
                default:  state_next = state;
            endcase
        end
    end

    always_comb begin
        busy     = (state == ST_LOAD);
        full     = (state == ST_DRAIN) || (state == ST_FULL);
        in_ready = busy && (!wr_valid || wr_ready) && !top_write;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_valid      <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            err           <= 1'b0;
            code_q        <= ERR_NONE;
            words_written <= '0;
        end else if (start) begin
            // re-arm discards any pending word
            wr_valid      <= 1'b0;
            wr_addr       <= base_addr;
            err           <= 1'b0;
            code_q        <= ERR_NONE;
            words_written <= '0;
        end else begin
            if (write_fire) begin
                words_written <= words_written + (IMEM_AW+1)'(1);
                if (!top_write) begin
                    wr_addr <= wr_addr + IMEM_AW'(1);
                end
            end
            if (accept) begin
                if (pk_err) begin
                    wr_valid <= 1'b0;
                    err      <= 1'b1;
                    if (!err) begin
                        code_q <= err_code_t'(pk_code);
                    end
                end else begin
                    wr_valid <= 1'b1;
                    wr_data  <= pk_word;
                end
            end else if (write_fire) begin
                wr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_ready = 1'b0;
    logic [1:0]  fmt = '0;
    logic [3:0]  opcode = '0;
    logic [2:0]  rd_addr = '0, ra_addr = '0, rb_addr = '0, func = '0;
    logic [7:0]  imm = '0, addr = '0;

    // DUT A: default 256-word memory
    logic        start_a = 1'b0, in_valid_a = 1'b0;
    logic [7:0]  base_a = '0;
    logic        in_ready_a, wr_valid_a, busy_a, full_a, err_a;
    logic [7:0]  wr_addr_a;
    logic [15:0] wr_data_a;
    logic [1:0]  err_code_a;
    logic [8:0]  words_a;

    // DUT B: 8-word memory for top-of-memory behaviour
    logic        start_b = 1'b0, in_valid_b = 1'b0;
    logic [2:0]  base_b = '0;
    logic        in_ready_b, wr_valid_b, busy_b, full_b, err_b;
    logic [2:0]  wr_addr_b;
    logic [15:0] wr_data_b;
    logic [1:0]  err_code_b;
    logic [3:0]  words_b;

    instr_encoder_loader #(.IMEM_AW(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .base_addr(base_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .fmt(fmt), .opcode(opcode),
        .rd_addr(rd_addr), .ra_addr(ra_addr), .rb_addr(rb_addr), .func(func),
        .imm(imm), .addr(addr), .wr_valid(wr_valid_a), .wr_ready(wr_ready),
        .wr_addr(wr_addr_a), .wr_data(wr_data_a), .busy(busy_a), .full(full_a),
        .err(err_a), .err_code(err_code_a), .words_written(words_a)
    );

    instr_encoder_loader #(.IMEM_AW(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .base_addr(base_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .fmt(fmt), .opcode(opcode),
        .rd_addr(rd_addr), .ra_addr(ra_addr), .rb_addr(rb_addr), .func(func),
        .imm(imm), .addr(addr), .wr_valid(wr_valid_b), .wr_ready(wr_ready),
        .wr_addr(wr_addr_b), .wr_data(wr_data_b), .busy(busy_b), .full(full_b),
        .err(err_b), .err_code(err_code_b), .words_written(words_b)
    );

    always #5 clk = ~clk;

    // wr_ready driver: 0 = hold low, 1 = hold high, 2 = random
    int rdy_mode = 1;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       wr_ready = 1'b0;
            1:       wr_ready = 1'b1;
            default: wr_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Write monitor for DUT A: logs completed writes, flags stall instability
    logic [7:0]  obs_addr[$];
    logic [15:0] obs_data[$];
    int          stab_viol = 0;
    bit          prev_stall = 0;
    logic [7:0]  prev_addr;
    logic [15:0] prev_data;
    always @(negedge clk) begin
        if (!rst_n || start_a) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && !(wr_valid_a === 1'b1 && wr_addr_a === prev_addr
                                && wr_data_a === prev_data))
                stab_viol++;
            if (wr_valid_a && wr_ready) begin
                obs_addr.push_back(wr_addr_a);
                obs_data.push_back(wr_data_a);
            end
            prev_stall = wr_valid_a && !wr_ready;
            prev_addr  = wr_addr_a;
            prev_data  = wr_data_a;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: encoding straight from the field layout rules
    function automatic void encode(input int f, input int op, input int rd, input int ra,
                                   input int rb, input int fn, input int im, input int ad,
                                   output logic [15:0] w, output bit ok, output int code);
        int s;
        int u;
        ok = 1; code = 0; w = '0;
        case (f)
            0: w = 16'(op*4096 + rd*512 + ra*64 + rb*8 + fn);
            1: begin
                s = (im >= 128) ? im - 256 : im;
                if (s < -32 || s > 31) begin ok = 0; code = 1; end
                u = s & 63;
                w = 16'(op*4096 + (u/8)*512 + ra*64 + rb*8 + (u%8));
            end
            2: begin
                s = (ad >= 128) ? ad - 256 : ad;
                if (s < -64 || s > 63) begin ok = 0; code = 2; end
                w = 16'(op*4096 + rd*512 + (s & 127));
            end
            default: begin ok = 0; code = 3; end
        endcase
    endfunction

    logic [7:0]  exp_addr[$];
    logic [15:0] exp_data[$];
    int          obs_base = 0;
    logic [7:0]  m_ptr = '0;
    bit          m_err = 0;
    int          m_code = 0;

    task automatic set_fields(input int f, input int op, input int rd, input int ra,
                              input int rb, input int fn, input int im, input int ad);
        fmt = 2'(f); opcode = 4'(op); rd_addr = 3'(rd); ra_addr = 3'(ra);
        rb_addr = 3'(rb); func = 3'(fn); imm = 8'(im); addr = 8'(ad);
    endtask

    task automatic arm_a(input logic [7:0] b);
        start_a = 1'b1; base_a = b;
        @(posedge clk); #1;
        start_a = 1'b0;
        m_ptr = b; m_err = 0; m_code = 0;
        exp_addr.delete(); exp_data.delete();
        obs_base = obs_addr.size();
    endtask

    task automatic arm_b(input logic [2:0] b);
        start_b = 1'b1; base_b = b;
        @(posedge clk); #1;
        start_b = 1'b0;
    endtask

    // Present the current fields to DUT A (sel=0) or B (sel=1); returns at
    // posedge+1 after the handshake.
    task automatic send(input bit sel);
        bit          got = 0;
        logic [15:0] w;
        bit          ok;
        int          code;
        if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if ((sel ? in_ready_b : in_ready_a) === 1'b1) begin
                got = 1;
                break;
            end
        end
        if (got) begin
            @(posedge clk); #1;
        end
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        if (!got) begin
            chk("accept_timeout", 32'(got), 32'd1);
        end else if (!sel) begin
            encode(int'(fmt), int'(opcode), int'(rd_addr), int'(ra_addr), int'(rb_addr),
                   int'(func), int'(imm), int'(addr), w, ok, code);
            if (ok) begin
                exp_addr.push_back(m_ptr);
                exp_data.push_back(w);
                m_ptr++;
            end else if (!m_err) begin
                m_err = 1;
                m_code = code;
            end
        end
    endtask

    task automatic drain_a;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!wr_valid_a) break;
        end
        chk("drain_wr_valid", 32'(wr_valid_a), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_writes;
        int n = obs_addr.size() - obs_base;
        chk("write_count", 32'(n), 32'(exp_addr.size()));
        for (int i = 0; i < n && i < exp_addr.size(); i++) begin
            chk("write_addr", 32'(obs_addr[obs_base+i]), 32'(exp_addr[i]));
            chk("write_data", 32'(obs_data[obs_base+i]), 32'(exp_data[i]));
        end
        chk("words_written", 32'(words_a), 32'(exp_addr.size()));
        chk("err", 32'(err_a), 32'(m_err));
        chk("err_code", 32'(err_code_a), 32'(m_code));
    endtask

    initial begin : main
        int  d6;
        bit  bad;
        // ---------------- reset values
        #3;
        chk("rst_wr_valid", 32'(wr_valid_a), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr_a), 32'd0);
        chk("rst_wr_data", 32'(wr_data_a), 32'd0);
        chk("rst_in_ready", 32'(in_ready_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_full", 32'(full_a), 32'd0);
        chk("rst_err", 32'({err_a, err_code_a}), 32'd0);
        chk("rst_words", 32'(words_a), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy_mode = 1;
        @(posedge clk); #1;

        // ---------------- R tuple, 1-cycle latency
        arm_a(8'h10);
        chk("busy_after_start", 32'(busy_a), 32'd1);
        set_fields(0, 4, 1, 2, 3, 5, 0, 0);
        send(0);
        chk("r_wr_valid", 32'(wr_valid_a), 32'd1);
        chk("r_wr_data", 32'(wr_data_a), 32'h429D);
        chk("r_wr_addr", 32'(wr_addr_a), 32'h10);
        @(posedge clk); #1;
        chk("r_words", 32'(words_a), 32'd1);

        // ---------------- I tuple with negative imm, decode round trip
        set_fields(1, 2, 7, 1, 0, 0, 8'hE5, 0);
        send(0);
        chk("i_wr_data", 32'(wr_data_a), 32'(exp_data[exp_data.size()-1]));
        d6 = int'(wr_data_a[11:9]) * 8 + int'(wr_data_a[2:0]);
        if (d6 >= 32) d6 -= 64;
        chk("i_decode_imm", 32'(d6), 32'(-27));
        @(posedge clk); #1;

        // ---------------- range errors, first cause sticks
        set_fields(1, 3, 0, 1, 1, 0, 8'h40, 0);
        send(0);
        chk("imm_err_no_write", 32'(wr_valid_a), 32'd0);
        chk("imm_err_flag", 32'(err_a), 32'd1);
        chk("imm_err_code", 32'(err_code_a), 32'd1);
        set_fields(2, 3, 0, 0, 0, 0, 0, 8'h80);
        send(0);
        chk("addr_err_no_write", 32'(wr_valid_a), 32'd0);
        chk("addr_err_code_kept", 32'(err_code_a), 32'd1);
        set_fields(2, 9, 5, 0, 0, 0, 0, 8'hC5);
        send(0);
        chk("after_err_wr_valid", 32'(wr_valid_a), 32'd1);
        chk("after_err_wr_data", 32'(wr_data_a), 32'(exp_data[exp_data.size()-1]));
        drain_a();
        check_writes();

        // ---------------- back-to-back burst with a 3-cycle stall
        arm_a(8'h40);
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    set_fields(0, i + 1, i, 7 - i, i, 3, 0, 0);
                    send(0);
                end
            end
            begin
                repeat (2) @(posedge clk);
                rdy_mode = 0;
                repeat (3) @(posedge clk);
                rdy_mode = 1;
            end
        join
        drain_a();
        check_writes();

        // ---------------- randomized stream against the model
        arm_a(8'($urandom_range(0, 128)));
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            set_fields($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2),
                       $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom_range(0, 2) == 0 ? $urandom_range(0, 255)
                                                 : ($urandom_range(0, 63) + 224) % 256,
                       $urandom_range(0, 2) == 0 ? $urandom_range(0, 255)
                                                 : ($urandom_range(0, 127) + 192) % 256);
            send(0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        rdy_mode = 1;
        @(posedge clk); #1;
        drain_a();
        check_writes();
        chk("stall_stability", 32'(stab_viol), 32'd0);

        // ---------------- top of memory on the 8-word instance
        arm_b(3'd6);
        set_fields(0, 1, 1, 1, 1, 1, 0, 0);
        send(1);
        chk("b_first_addr", 32'(wr_addr_b), 32'd6);
        set_fields(0, 2, 2, 2, 2, 2, 0, 0);
        send(1);
        chk("b_second_addr", 32'(wr_addr_b), 32'd7);
        chk("b_second_valid", 32'(wr_valid_b), 32'd1);
        @(negedge clk);
        chk("b_top_in_ready", 32'(in_ready_b), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("b_full", 32'(full_b), 32'd1);
        chk("b_busy", 32'(busy_b), 32'd0);
        chk("b_words", 32'(words_b), 32'd2);
        chk("b_wr_valid_idle", 32'(wr_valid_b), 32'd0);
        @(negedge clk);
        chk("b_full_in_ready", 32'(in_ready_b), 32'd0);
        @(posedge clk); #1;
        arm_b(3'd0);
        chk("b_rearm_full", 32'(full_b), 32'd0);
        chk("b_rearm_busy", 32'(busy_b), 32'd1);
        chk("b_rearm_words", 32'(words_b), 32'd0);

        // ---------------- async reset with a stalled word
        rdy_mode = 0;
        @(posedge clk); #1;
        arm_a(8'h20);
        set_fields(0, 5, 1, 1, 1, 1, 0, 0);
        send(0);
        chk("pre_rst_wr_valid", 32'(wr_valid_a), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wr_valid", 32'(wr_valid_a), 32'd0);
        chk("arst_wr_addr", 32'(wr_addr_a), 32'd0);
        chk("arst_wr_data", 32'(wr_data_a), 32'd0);
        chk("arst_flags", 32'({in_ready_a, busy_a, full_a, err_a, err_code_a}), 32'd0);
        chk("arst_words", 32'(words_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 1;
        @(posedge clk); #1;
        in_valid_a = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (wr_valid_a !== 1'b0 || in_ready_a !== 1'b0) bad = 1;
        end
        in_valid_a = 1'b0;
        chk("post_rst_idle", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
